// File: rtl/blake_msg_sched_if.sv
// Issue/handshake bundle between the block source, blake_msg_sched and the BLAKE-256 G pipeline.
interface blake_msg_sched_if;
    logic         start;
    logic [511:0] msg_in;
    logic         g_ready;
    logic         busy;
    logic         g_valid;
    logic [3:0]   g_round;
    logic [2:0]   g_idx;
    logic [31:0]  msg_i;
    logic         msg_i_valid;
    logic [31:0]  msg_ip;
    logic         msg_ip_valid;
    logic         done;

    modport master (
        output start, msg_in, g_ready,
        input  busy, g_valid, g_round, g_idx, msg_i, msg_i_valid, msg_ip, msg_ip_valid, done
    );

    modport slave (
        input  start, msg_in, g_ready,
        output busy, g_valid, g_round, g_idx, msg_i, msg_i_valid, msg_ip, msg_ip_valid, done
    );
endinterface

// File: rtl/blake_msg_sched.sv
// BLAKE-256 message/constant schedule: walks ROUNDS x 8 G operations and presents
// m[s]^c[s'] words at the G pipeline's sampling offsets (issue+1 and issue+4).
module blake_msg_sched #(
    parameter int unsigned ROUNDS = 8
) (
    input  logic             clk,
    input  logic             reset,
    blake_msg_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t       state, state_nxt;
    logic [511:0] msg_q;
    logic [3:0]   round_q;
    logic [2:0]   idx_q;
    logic         busy_q, gvalid_q, done_q;
    logic [31:0]  mi_q, mip_q;
    logic         mi_valid_q, mip_valid_q;
    logic [31:0]  ip_dly [3];
    logic [2:0]   ip_vld, ip_last;

    logic         issue, last_issue;
    logic [3:0]   row, s_even, s_odd;
    logic [63:0]  perm;
    logic [31:0]  word_i, word_ip;

    // Row entries packed with position 0 in the low nibble.
    function automatic logic [63:0] sigma_row(input logic [3:0] r);
        case (r)
            4'd1:    sigma_row = 64'h357B20C16DF984AE;
            4'd2:    sigma_row = 64'h491763EADF250C8B;
            4'd3:    sigma_row = 64'h8F04A562EBCD1397;
            4'd4:    sigma_row = 64'hD386CB1EFA427509;
            4'd5:    sigma_row = 64'h91EF57D438B0A6C2;
            4'd6:    sigma_row = 64'hB8293670A4DEF15C;
            4'd7:    sigma_row = 64'hA2684F05931CE7BD;
            4'd8:    sigma_row = 64'h5A417D2C803B9EF6;
            4'd9:    sigma_row = 64'h0DC3E9BF5167482A;
            default: sigma_row = 64'hFEDCBA9876543210;
        endcase
    endfunction

    function automatic logic [31:0] blake_c(input logic [3:0] i);
        case (i)
            4'd0:    blake_c = 32'h243F6A88;
            4'd1:    blake_c = 32'h85A308D3;
            4'd2:    blake_c = 32'h13198A2E;
            4'd3:    blake_c = 32'h03707344;
            4'd4:    blake_c = 32'hA4093822;
            4'd5:    blake_c = 32'h299F31D0;
            4'd6:    blake_c = 32'h082EFA98;
            4'd7:    blake_c = 32'hEC4E6C89;
            4'd8:    blake_c = 32'h452821E6;
            4'd9:    blake_c = 32'h38D01377;
            4'd10:   blake_c = 32'hBE5466CF;
            4'd11:   blake_c = 32'h34E90C6C;
            4'd12:   blake_c = 32'hC0AC29B7;
            4'd13:   blake_c = 32'hC97C50DD;
            4'd14:   blake_c = 32'h3F84D5B5;
            default: blake_c = 32'hB5470917;
        endcase
    endfunction

    assign issue      = gvalid_q && bus.g_ready;
    assign last_issue = issue && (round_q == 4'(ROUNDS - 1)) && (idx_q == 3'd7);

    // Rounds 10..13 reuse rows 0..3; g_round never exceeds 13.
    assign row     = (round_q >= 4'd10) ? round_q - 4'd10 : round_q;
    assign perm    = sigma_row(row);
    assign s_even  = perm[{idx_q, 3'b000} +: 4];
    assign s_odd   = perm[{idx_q, 3'b100} +: 4];
    assign word_i  = msg_q[{s_even, 5'b00000} +: 32] ^ blake_c(s_odd);
    assign word_ip = msg_q[{s_odd, 5'b00000} +: 32] ^ blake_c(s_even);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (done_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_q       <= '0;
            round_q     <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            gvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            mi_q        <= '0;
            mi_valid_q  <= 1'b0;
            mip_q       <= '0;
            mip_valid_q <= 1'b0;
            ip_dly      <= '{default: '0};
            ip_vld      <= '0;
            ip_last     <= '0;
        end else begin
            busy_q   <= (state_nxt != IDLE);
            gvalid_q <= (state_nxt == ISSUE);

            if (state == IDLE && bus.start) begin
                msg_q   <= bus.msg_in;
                round_q <= '0;
                idx_q   <= '0;
            end else if (issue && !last_issue) begin
                idx_q <= idx_q + 3'd1;
                if (idx_q == 3'd7) round_q <= round_q + 4'd1;
            end

            mi_valid_q <= issue;
            if (issue) mi_q <= word_i;

            // msg_ip rides a free-running 3-stage line, then the output register.
            ip_dly[0] <= word_ip;
            ip_dly[1] <= ip_dly[0];
            ip_dly[2] <= ip_dly[1];
            ip_vld    <= {ip_vld[1:0], issue};
            ip_last   <= {ip_last[1:0], last_issue};

            mip_valid_q <= ip_vld[2];
            if (ip_vld[2]) mip_q <= ip_dly[2];
            done_q <= ip_last[2];
        end
    end

    assign bus.busy         = busy_q;
    assign bus.g_valid      = gvalid_q;
    assign bus.g_round      = round_q;
    assign bus.g_idx        = idx_q;
    assign bus.msg_i        = mi_q;
    assign bus.msg_i_valid  = mi_valid_q;
    assign bus.msg_ip       = mip_q;
    assign bus.msg_ip_valid = mip_valid_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_blake_msg_sched.sv
// Bench for blake_msg_sched: ROUNDS=8 and ROUNDS=14 instances share stimulus and are
// checked cycle by cycle against a timestamped reference scoreboard plus directed vectors.
module tb_blake_msg_sched;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [511:0] msg_in;
    logic g_ready;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    blake_msg_sched_if bus8 ();
    blake_msg_sched_if bus14 ();

    blake_msg_sched #(.ROUNDS(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
    blake_msg_sched #(.ROUNDS(14)) dut14 (.clk(clk), .reset(reset), .bus(bus14.slave));

    assign bus8.start    = start;
    assign bus8.msg_in   = msg_in;
    assign bus8.g_ready  = g_ready;
    assign bus14.start   = start;
    assign bus14.msg_in  = msg_in;
    assign bus14.g_ready = g_ready;

    logic [1:0]  o_busy, o_gv, o_miv, o_mipv, o_done;
    logic [3:0]  o_round [2];
    logic [2:0]  o_idx [2];
    logic [31:0] o_mi [2];
    logic [31:0] o_mip [2];
    assign o_busy = {bus14.busy, bus8.busy};
    assign o_gv   = {bus14.g_valid, bus8.g_valid};
    assign o_miv  = {bus14.msg_i_valid, bus8.msg_i_valid};
    assign o_mipv = {bus14.msg_ip_valid, bus8.msg_ip_valid};
    assign o_done = {bus14.done, bus8.done};
    assign o_round[0] = bus8.g_round;
    assign o_round[1] = bus14.g_round;
    assign o_idx[0]   = bus8.g_idx;
    assign o_idx[1]   = bus14.g_idx;
    assign o_mi[0]    = bus8.msg_i;
    assign o_mi[1]    = bus14.msg_i;
    assign o_mip[0]   = bus8.msg_ip;
    assign o_mip[1]   = bus14.msg_ip;

    int unsigned sig [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };
    logic [31:0] cst [16] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
        32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
        32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917
    };

    function automatic logic [31:0] model_word(input logic [511:0] m, input int r, input int g,
                                               input bit second);
        int unsigned a, b;
        a = sig[r % 10][2*g];
        b = sig[r % 10][2*g + 1];
        if (!second) return m[a*32 +: 32] ^ cst[b];
        return m[b*32 +: 32] ^ cst[a];
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // Scoreboard: each issue schedules its two words at absolute cycle numbers.
    typedef struct {
        int          k;
        int          due;
        logic [31:0] w;
        bit          last;
        int          r;
        int          g;
    } item_t;
    item_t qi [$];
    item_t qp [$];

    bit           mbusy [2];
    bit           mgv [2];
    int           mr [2];
    int           mg [2];
    logic [511:0] mmsg [2];
    int           issues [2];
    int           done_cnt [2];
    int           acc [2];
    int           lat [2];
    logic [31:0]  obs_i [2][14][8];
    logic [31:0]  obs_p [2][14][8];

    always @(negedge clk) begin
        if (reset) begin
            qi.delete();
            qp.delete();
            for (int k = 0; k < 2; k++) begin
                mbusy[k] = 1'b0;
                mgv[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int    R, ri, rp;
                bit    cur_busy, cur_gv, exp_done, last;
                item_t it;
                R  = (k == 0) ? 8 : 14;
                ri = -1;
                rp = -1;
                cur_busy = mbusy[k];
                cur_gv   = mgv[k];
                foreach (qi[j]) if (qi[j].k == k && qi[j].due == cyc) ri = j;
                foreach (qp[j]) if (qp[j].k == k && qp[j].due == cyc) rp = j;

                check("busy", k, o_busy[k], cur_busy);
                check("g_valid", k, o_gv[k], cur_gv);
                check("msg_i_valid", k, o_miv[k], ri >= 0);
                check("msg_ip_valid", k, o_mipv[k], rp >= 0);
                exp_done = (rp >= 0) && qp[rp].last;
                check("done", k, o_done[k], exp_done);
                if (ri >= 0) begin
                    check("msg_i", k, o_mi[k], qi[ri].w);
                    obs_i[k][qi[ri].r][qi[ri].g] = o_mi[k];
                    qi.delete(ri);
                end
                if (rp >= 0) begin
                    check("msg_ip", k, o_mip[k], qp[rp].w);
                    obs_p[k][qp[rp].r][qp[rp].g] = o_mip[k];
                    qp.delete(rp);
                end
                if (cur_gv) begin
                    check("g_round", k, o_round[k], mr[k]);
                    check("g_idx", k, o_idx[k], mg[k]);
                end

                if (!cur_busy && start) begin
                    mbusy[k] = 1'b1;
                    mgv[k]   = 1'b1;
                    mr[k]    = 0;
                    mg[k]    = 0;
                    mmsg[k]  = msg_in;
                    issues[k] = 0;
                    acc[k]   = cyc;
                    for (int r = 0; r < 14; r++)
                        for (int g = 0; g < 8; g++) begin
                            obs_i[k][r][g] = '0;
                            obs_p[k][r][g] = '0;
                        end
                end

                if (cur_gv && g_ready) begin
                    last   = (mr[k] == R - 1) && (mg[k] == 7);
                    it.k   = k;
                    it.r   = mr[k];
                    it.g   = mg[k];
                    it.due = cyc + 1;
                    it.w   = model_word(mmsg[k], mr[k], mg[k], 1'b0);
                    it.last = 1'b0;
                    qi.push_back(it);
                    it.due = cyc + 4;
                    it.w   = model_word(mmsg[k], mr[k], mg[k], 1'b1);
                    it.last = last;
                    qp.push_back(it);
                    issues[k]++;
                    if (last) mgv[k] = 1'b0;
                    else if (mg[k] == 7) begin
                        mg[k] = 0;
                        mr[k]++;
                    end else mg[k]++;
                end

                if (exp_done) begin
                    check("issue_count", k, issues[k], 8 * R);
                    done_cnt[k]++;
                    lat[k]   = cyc - acc[k];
                    mbusy[k] = 1'b0;
                end
            end
        end
    end

    // Caller must be mid-cycle (after a posedge); start is raised in the current cycle.
    task automatic run_block(input logic [511:0] m, input bit rand_ready, input bit hold_start);
        int d8, d14, budget;
        d8  = done_cnt[0];
        d14 = done_cnt[1];
        msg_in  = m;
        start   = 1'b1;
        g_ready = 1'b1;
        budget  = 0;
        while ((done_cnt[0] == d8 || done_cnt[1] == d14) && budget < 1000) begin
            @(posedge clk);
            #1;
            budget++;
            if (!hold_start || done_cnt[0] != d8) start = 1'b0;
            g_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (budget == 10) msg_in = {16{$urandom()}};
        end
        start   = 1'b0;
        g_ready = 1'b1;
        check("block_finished", 0, budget < 1000, 1'b1);
        check("done_once8", 0, done_cnt[0], d8 + 1);
        check("done_once14", 1, done_cnt[1], d14 + 1);
        if (!rand_ready) begin
            check("latency", 0, lat[0], 8 * 8 + 4);
            check("latency", 1, lat[1], 8 * 14 + 4);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 0, {bus14.busy, bus8.busy}, 0);
        check({tag, "_g_valid"}, 0, {bus14.g_valid, bus8.g_valid}, 0);
        check({tag, "_g_round"}, 0, {bus14.g_round, bus8.g_round}, 0);
        check({tag, "_g_idx"}, 0, {bus14.g_idx, bus8.g_idx}, 0);
        check({tag, "_msg_i8"}, 0, bus8.msg_i, 0);
        check({tag, "_msg_i14"}, 1, bus14.msg_i, 0);
        check({tag, "_msg_ip8"}, 0, bus8.msg_ip, 0);
        check({tag, "_msg_ip14"}, 1, bus14.msg_ip, 0);
        check({tag, "_valids"}, 0, {o_miv, o_mipv}, 0);
        check({tag, "_done"}, 0, o_done, 0);
    endtask

    typedef struct {
        int           inst;
        int           r;
        int           g;
        logic [511:0] msg;
        logic [31:0]  ei;
        logic [31:0]  ep;
    } vec_t;

    initial begin
        vec_t         vecs [11];
        logic [511:0] mz, mf, m5, last_msg;
        int           d8, d14, budget;

        mz = '0;
        mf = '0;
        mf[31:0] = 32'hFFFFFFFF;
        m5 = '0;
        m5[191:160] = 32'h12345678;
        vecs[0]  = '{0,  0, 0, mz, 32'h85A308D3, 32'h243F6A88};
        vecs[1]  = '{0,  1, 0, mz, 32'hBE5466CF, 32'h3F84D5B5};
        vecs[2]  = '{0,  0, 1, mz, 32'h03707344, 32'h13198A2E};
        vecs[3]  = '{0,  0, 7, mz, 32'hB5470917, 32'h3F84D5B5};
        vecs[4]  = '{0,  1, 1, mz, 32'h452821E6, 32'hA4093822};
        vecs[5]  = '{1, 10, 0, mz, 32'h85A308D3, 32'h243F6A88};
        vecs[6]  = '{1, 11, 0, mz, 32'hBE5466CF, 32'h3F84D5B5};
        vecs[7]  = '{0,  0, 0, mf, 32'h7A5CF72C, 32'h243F6A88};
        vecs[8]  = '{0,  1, 7, m5, 32'h1144253C, 32'h299F31D0};
        vecs[9]  = '{1, 13, 5, m5, 32'hAC6030B7, 32'h299F31D0};
        vecs[10] = '{0,  3, 5, m5, 32'hAC6030B7, 32'h299F31D0};

        reset   = 1'b1;
        start   = 1'b0;
        msg_in  = '0;
        g_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #2 reset = 1'b0;

        last_msg = '0;
        for (int v = 0; v < 11; v++) begin
            if (v == 0 || vecs[v].msg !== last_msg) begin
                run_block(vecs[v].msg, 1'b0, 1'b0);
                last_msg = vecs[v].msg;
            end
            check("vec_msg_i", vecs[v].inst, obs_i[vecs[v].inst][vecs[v].r][vecs[v].g], vecs[v].ei);
            check("vec_msg_ip", vecs[v].inst, obs_p[vecs[v].inst][vecs[v].r][vecs[v].g], vecs[v].ep);
        end

        run_block({16{$urandom()}}, 1'b0, 1'b0);
        run_block({16{$urandom()}}, 1'b1, 1'b0);
        run_block({16{$urandom()}}, 1'b1, 1'b1);
        run_block({16{$urandom()}}, 1'b0, 1'b1);

        // Abort during round 3, then a clean block afterwards.
        d8  = done_cnt[0];
        d14 = done_cnt[1];
        msg_in  = {16{$urandom()}};
        start   = 1'b1;
        g_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        budget = 0;
        while (bus8.g_round != 4'd3 && budget < 200) begin
            @(posedge clk);
            #1 budget++;
        end
        check("reach_round3", 0, bus8.g_round, 4'd3);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_done_after_abort", 0, done_cnt[0], d8);
        check("no_done_after_abort", 1, done_cnt[1], d14);
        run_block({16{$urandom()}}, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
